fpmul_arbiter: RTL

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fpmul among N_REQ requesters.
// Optional watchdog on the fpmul wait enabled by defining FPMUL_ARB_WDT_EN.
`timescale 1ns/1ps
module fpmul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_BIT   = 32,
    parameter int ID_BIT  = $clog2(N_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*N_BIT-1:0] req_a,
    input  logic [N_REQ*N_BIT-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_BIT-1:0]      rsp_id,
    output logic [N_BIT-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic [N_BIT-1:0]       mul_a,
    output logic [N_BIT-1:0]       mul_b,
    output logic                   mul_start,
    input  logic                   mul_ready,
    input  logic [N_BIT-1:0]       mul_out,
    output logic                   busy
);
    localparam int CW = ID_BIT + 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("fpmul_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_BIT-1:0] ptr_q, ptr_d;
    logic [ID_BIT-1:0] id_q, id_d;
    logic [N_BIT-1:0]  a_q, a_d;
    logic [N_BIT-1:0]  b_q, b_d;
    logic [N_BIT-1:0]  data_q, data_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              gnt_found_s;
    logic [ID_BIT-1:0] gnt_id_s;
    logic              grant_s;
    logic [N_BIT-1:0]  sel_a_s, sel_b_s;

    // Round-robin search: lowest offset from ptr+1 wins, so scan offsets high to low.
    always_comb begin
        logic [CW-1:0] cand;
        cand        = '0;
        gnt_found_s = 1'b0;
        gnt_id_s    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end else begin
                cand = cand;
            end
            if (req_valid[cand[ID_BIT-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_id_s    = cand[ID_BIT-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Operand select for the winning requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id_s == ID_BIT'(i)) begin
                sel_a_s = req_a[i*N_BIT +: N_BIT];
                sel_b_s = req_b[i*N_BIT +: N_BIT];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Accept strobe is combinational so the grant lands in the cycle req_valid is seen.
    assign grant_s   = rst_n && (state_q == IDLE) && gnt_found_s;
    assign req_ready = grant_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_s) : {N_REQ{1'b0}};

`ifdef FPMUL_ARB_WDT_EN
    localparam int WDT_BIT = $clog2(TIMEOUT + 1);

    // Canonical quiet NaN for the supported IEEE widths.
    function automatic logic [N_BIT-1:0] qnan_f();
        logic [N_BIT-1:0] v;
        case (N_BIT)
            16:      v = N_BIT'(16'h7E00);
            64:      v = N_BIT'(64'h7FF8_0000_0000_0000);
            default: v = N_BIT'(32'h7FC0_0000);
        endcase
        return v;
    endfunction

    logic [WDT_BIT-1:0] wdt_q, wdt_d;
    logic               err_q, err_d;
    logic               wdt_exp_s;

    assign wdt_exp_s = (wdt_q == WDT_BIT'(TIMEOUT - 1));

    // Watchdog count and error flag.
    always_comb begin
        wdt_d = wdt_q;
        err_d = err_q;
        if (state_q == ISSUE) begin
            wdt_d = '0;
        end else if (state_q == WAIT) begin
            wdt_d = wdt_q + WDT_BIT'(1);
        end else begin
            wdt_d = wdt_q;
        end
        if (grant_s) begin
            err_d = 1'b0;
        end else if (state_q == WAIT && !mul_ready && wdt_exp_s) begin
            err_d = 1'b1;
        end else if (state_q == RESP && rsp_ready) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Next-state and datapath capture.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = ISSUE;
                    id_d    = gnt_id_s;
                    a_d     = sel_a_s;
                    b_d     = sel_b_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_ready) begin
                    data_d  = mul_out;
                    state_d = RESP;
                end
`ifdef FPMUL_ARB_WDT_EN
                else if (wdt_exp_s) begin
                    data_d  = qnan_f();
                    state_d = RESP;
                end
`endif
                else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = id_q;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        start_d = (state_d == ISSUE);
        valid_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= ID_BIT'(N_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            start_q <= start_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_start = start_q;
    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = busy_q;

endmodule
